// File: rtl/transformation_engine.sv
// Feature x weight-matrix transform engine: streams weight columns and feature rows from memory and writes every dot product.
// Optional build macro TRANSFORM_SATURATE_EN clamps results to the PROD_WIDTH maximum instead of wrapping them.
module transformation_engine #(
    parameter int unsigned NUM_FEATURES    = 6,
    parameter int unsigned NUM_WEIGHT_COLS = 3,
    parameter int unsigned VEC_LEN         = 96,
    parameter int unsigned DATA_WIDTH      = 5,
    parameter int unsigned PROD_WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH      = 13,
    parameter int unsigned WEIGHT_BASE     = 0,
    parameter int unsigned FEATURE_BASE    = 512,
    localparam int unsigned ROW_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
    localparam int unsigned COL_W = (NUM_WEIGHT_COLS > 1) ? $clog2(NUM_WEIGHT_COLS) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0]    data_in,
    output logic                                  read_enable,
    output logic [ADDR_WIDTH-1:0]                 read_address,
    output logic                                  wr_en,
    output logic [ROW_W-1:0]                      wr_row,
    output logic [COL_W-1:0]                      wr_col,
    output logic [PROD_WIDTH-1:0]                 wr_data,
    output logic                                  busy,
    output logic                                  done
);

    localparam int unsigned MUL_W = 2 * DATA_WIDTH;
    localparam int unsigned ACC_W = PROD_WIDTH + $clog2(VEC_LEN);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_W  = 3'd1,
        LOAD_W = 3'd2,
        REQ_F  = 3'd3,
        CALC   = 3'd4,
        FINISH = 3'd5
    } state_e;

    state_e                             state_q, state_d;
    logic [ROW_W-1:0]                   row_q, row_d;
    logic [COL_W-1:0]                   col_q, col_d;
    logic [VEC_LEN-1:0][DATA_WIDTH-1:0] pad_q, pad_d;
    logic                               rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]              rd_addr_q, rd_addr_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic [ACC_W-1:0]                   sum_c;
    logic [PROD_WIDTH-1:0]              res_c;

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            pad_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pad_q     <= pad_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; registered outputs are derived from the state being entered
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        pad_d     = pad_q;
        rd_addr_d = rd_addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ_W;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            REQ_W:  state_d = LOAD_W;
            LOAD_W: begin
                pad_d   = data_in;
                state_d = REQ_F;
            end
            REQ_F:  state_d = CALC;
            CALC: begin
                if (row_q < ROW_W'(NUM_FEATURES - 1)) begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = REQ_F;
                end else if (col_q < COL_W'(NUM_WEIGHT_COLS - 1)) begin
                    row_d   = '0;
                    col_d   = col_q + COL_W'(1);
                    state_d = REQ_W;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rd_en_d = (state_d == REQ_W) || (state_d == REQ_F);
        if (state_d == REQ_W) begin
            rd_addr_d = ADDR_WIDTH'(WEIGHT_BASE) + ADDR_WIDTH'(col_d);
        end else if (state_d == REQ_F) begin
            rd_addr_d = ADDR_WIDTH'(FEATURE_BASE) + ADDR_WIDTH'(row_d);
        end
        busy_d = (state_d == REQ_W) || (state_d == LOAD_W) ||
                 (state_d == REQ_F) || (state_d == CALC);
        done_d = (state_d == FINISH);
    end

    // Dot product of the arriving feature row against the latched weight column
    always_comb begin
        sum_c = '0;
        for (int unsigned k = 0; k < VEC_LEN; k++) begin
            sum_c = sum_c + ACC_W'(MUL_W'(data_in[k]) * MUL_W'(pad_q[k]));
        end
    end

`ifdef TRANSFORM_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({PROD_WIDTH{1'b1}});
    assign res_c = (sum_c > SAT_MAX) ? {PROD_WIDTH{1'b1}} : PROD_WIDTH'(sum_c);
`else
    assign res_c = PROD_WIDTH'(sum_c);
`endif

    // Result write happens in the same cycle the feature row arrives
    assign wr_en        = (state_q == CALC);
    assign wr_data      = (state_q == CALC) ? res_c : '0;
    assign wr_row       = row_q;
    assign wr_col       = col_q;
    assign read_enable  = rd_en_q;
    assign read_address = rd_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_transformation_engine.sv
// Self-checking bench for transformation_engine: memory model, scoreboard of expected writes, directed runs.
module tb_transformation_engine;

    localparam int NF    = 6;
    localparam int NWC   = 3;
    localparam int VL    = 96;
    localparam int DW    = 5;
    localparam int PW    = 16;
    localparam int AW    = 13;
    localparam int WB    = 0;
    localparam int FB    = 512;
    localparam int ROW_W = 3;
    localparam int COL_W = 2;
    localparam int LAT   = NWC * (2 + 2 * NF) + 1;

    typedef logic [VL-1:0][DW-1:0] vec_t;
    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [PW-1:0]    data;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    vec_t             data_in = '0;
    logic             read_enable;
    logic [AW-1:0]    read_address;
    logic             wr_en;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;
    logic [PW-1:0]    wr_data;
    logic             busy;
    logic             done;

    vec_t fmem [NF];
    vec_t wmem [NWC];
    exp_t sb [$];

    int compared = 0;
    int mismatched = 0;
    int cyc, writes, dones, busy_cnt, done_cyc;

    transformation_engine dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .data_in      (data_in),
        .read_enable  (read_enable),
        .read_address (read_address),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t rd(input logic [AW-1:0] a);
        int ai;
        ai = int'(a);
        if (ai >= WB && ai < WB + NWC) return wmem[ai - WB];
        if (ai >= FB && ai < FB + NF) return fmem[ai - FB];
        return '0;
    endfunction

    // Memory model: one-cycle read latency
    always @(posedge clk) begin
        if (read_enable) data_in <= rd(read_address);
    end

    function automatic logic [PW-1:0] model(input int r, input int c);
        int unsigned s;
        s = 0;
        for (int k = 0; k < VL; k++) s += 32'(fmem[r][k]) * 32'(wmem[c][k]);
`ifdef TRANSFORM_SATURATE_EN
        if (s > 32'd65535) return '1;
`endif
        return PW'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int mode, input int fv, input int wv);
        for (int r = 0; r < NF; r++)
            for (int k = 0; k < VL; k++)
                fmem[r][k] = (mode == 0) ? DW'(fv) : (mode == 1) ? DW'(r) : DW'($urandom_range(0, 31));
        for (int c = 0; c < NWC; c++)
            for (int k = 0; k < VL; k++)
                wmem[c][k] = (mode == 0) ? DW'(wv) : (mode == 1) ? DW'(c + 1) : DW'($urandom_range(0, 31));
    endtask

    task automatic push_expected();
        for (int c = 0; c < NWC; c++)
            for (int r = 0; r < NF; r++)
                sb.push_back('{row: ROW_W'(r), col: COL_W'(c), data: model(r, c)});
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (busy) busy_cnt++;
        if (done) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
            check("busy_low_at_done", 32'(busy), 32'd0);
        end
        if (wr_en) begin
            writes++;
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_row", 32'(wr_row), 32'(e.row));
                check("wr_col", 32'(wr_col), 32'(e.col));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    endtask

    task automatic begin_run();
        push_expected();
        writes = 0; dones = 0; busy_cnt = 0; done_cyc = -1;
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "/read_enable"},  32'(read_enable),  32'd0);
        check({name, "/read_address"}, 32'(read_address), 32'd0);
        check({name, "/wr_en"},        32'(wr_en),        32'd0);
        check({name, "/wr_row"},       32'(wr_row),       32'd0);
        check({name, "/wr_col"},       32'(wr_col),       32'd0);
        check({name, "/wr_data"},      32'(wr_data),      32'd0);
        check({name, "/busy"},         32'(busy),         32'd0);
        check({name, "/done"},         32'(done),         32'd0);
    endtask

    // Full transform; p1/p2 are cycles (start cycle = 0) on which a stray start is pulsed
    task automatic run(input string name, input int p1, input int p2);
        begin_run();
        check({name, "/rd_en_c1"},   32'(read_enable),  32'd1);
        check({name, "/rd_addr_c1"}, 32'(read_address), 32'(WB));
        check({name, "/busy_c1"},    32'(busy),         32'd1);
        while (done_cyc < 0 && cyc < LAT + 20) begin
            start = (cyc == p1) || (cyc == p2);
            tick();
        end
        repeat (4) begin
            start = (cyc == p1) || (cyc == p2);
            tick();
        end
        start = 1'b0;
        check({name, "/writes"},    32'(writes),   32'(NF * NWC));
        check({name, "/dones"},     32'(dones),    32'd1);
        check({name, "/done_cyc"},  32'(done_cyc), 32'(LAT));
        check({name, "/busy_cnt"},  32'(busy_cnt), 32'(LAT - 1));
        check({name, "/sb_empty"},  32'(sb.size()), 32'd0);
        check({name, "/idle_busy"}, 32'(busy),     32'd0);
        sb.delete();
    endtask

    initial begin
        // Reset values
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // F=1, W=2: every result 192
        fill(0, 1, 2);
        run("ones_twos", -1, -1);

        // F[r][k]=r, W[c][k]=c+1: 96*r*(c+1), column-major order
        fill(1, 0, 0);
        run("pattern", -1, -1);

        // All 31s: sum 92256 wraps or saturates
        fill(0, 31, 31);
        run("overflow", -1, -1);

        // Stray starts while busy and during FINISH are ignored
        fill(2, 0, 0);
        run("start_busy", 5, 20);
        fill(2, 0, 0);
        run("start_finish", 1, LAT);

        // Reset during the 3rd write abandons the transform
        fill(2, 0, 0);
        begin_run();
        while (writes < 3 && cyc < 100) tick();
        check("abort/third_write", 32'(writes), 32'd3);
        reset = 1'b1;
        #1;
        check_outputs_zero("abort_reset");
        repeat (3) begin
            tick();
            check("abort/wr_en_in_reset", 32'(wr_en), 32'd0);
            check("abort/busy_in_reset", 32'(busy), 32'd0);
        end
        reset = 1'b0;
        sb.delete();
        repeat (3) tick();
        check("abort/no_more_writes", 32'(writes), 32'd3);
        check("abort/idle_rd_en", 32'(read_enable), 32'd0);
        run("restart", -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
